// File: rtl/cart_mmc1_if.sv
// Cartridge edge connector: CPU bus, PPU bus, CIRAM control and image loader port.
interface cart_mmc1_if;
  logic        prg_nce_in;
  logic [14:0] prg_a_in;
  logic        prg_r_nw_in;
  logic [7:0]  prg_d_in;
  logic [7:0]  prg_d_out;
  logic [13:0] chr_a_in;
  logic        chr_r_nw_in;
  logic [7:0]  chr_d_in;
  logic [7:0]  chr_d_out;
  logic        ciram_nce_out;
  logic        ciram_a10_out;
  logic        ld_we_in;
  logic        ld_sel_in;
  logic [16:0] ld_a_in;
  logic [7:0]  ld_d_in;

  modport master (
    output prg_nce_in, prg_a_in, prg_r_nw_in, prg_d_in,
    output chr_a_in, chr_r_nw_in, chr_d_in,
    output ld_we_in, ld_sel_in, ld_a_in, ld_d_in,
    input  prg_d_out, chr_d_out, ciram_nce_out, ciram_a10_out
  );

  modport slave (
    input  prg_nce_in, prg_a_in, prg_r_nw_in, prg_d_in,
    input  chr_a_in, chr_r_nw_in, chr_d_in,
    input  ld_we_in, ld_sel_in, ld_a_in, ld_d_in,
    output prg_d_out, chr_d_out, ciram_nce_out, ciram_a10_out
  );
endinterface

// File: rtl/cart_mmc1.sv
// NES cartridge model: NROM or MMC1 bank switching over internal PRG/CHR block RAMs,
// with a loader port for filling the images.
module cart_mmc1 #(
  parameter int MAPPER         = 1,
  parameter int PRG_BANKS_LOG2 = 3,
  parameter int CHR_BANKS_LOG2 = 3,
  parameter int CHR_RAM        = 0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       mirror_cfg_in,
  cart_mmc1_if.slave bus
);
  localparam int PRG_AW    = 14 + PRG_BANKS_LOG2;
  localparam int CHR_AW    = 12 + CHR_BANKS_LOG2;
  localparam int PRG_DEPTH = 1 << PRG_AW;
  localparam int CHR_DEPTH = 1 << CHR_AW;

  logic [4:0] control_reg, control_next;
  logic [4:0] chr0_reg, chr0_next;
  logic [4:0] chr1_reg, chr1_next;
  logic [4:0] prg_reg, prg_next;
  logic [3:0] shift_reg, shift_next;
  logic [2:0] count_reg, count_next;
  logic       wr_prev_reg;
  logic       cpu_wr;
  logic       wr_edge;
  logic [4:0] load_value;

  assign cpu_wr     = ~bus.prg_nce_in & ~bus.prg_r_nw_in;
  assign wr_edge    = (MAPPER == 1) && cpu_wr && !wr_prev_reg;
  assign load_value = {bus.prg_d_in[0], shift_reg};

  // Serial loader: bits enter LSB-first, the fifth write commits to the register picked by A14:A13.
  always_comb begin
    control_next = control_reg;
    chr0_next    = chr0_reg;
    chr1_next    = chr1_reg;
    prg_next     = prg_reg;
    shift_next   = shift_reg;
    count_next   = count_reg;
    if (wr_edge) begin
      if (bus.prg_d_in[7]) begin
        shift_next   = '0;
        count_next   = '0;
        control_next = control_reg | 5'b01100;
      end else if (count_reg == 3'd4) begin
        shift_next = '0;
        count_next = '0;
        case (bus.prg_a_in[14:13])
          2'd0:    control_next = load_value;
          2'd1:    chr0_next    = load_value;
          2'd2:    chr1_next    = load_value;
          default: prg_next     = load_value;
        endcase
      end else begin
        shift_next = {bus.prg_d_in[0], shift_reg[3:1]};
        count_next = count_reg + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      control_reg <= 5'b01100;
      chr0_reg    <= '0;
      chr1_reg    <= '0;
      prg_reg     <= '0;
      shift_reg   <= '0;
      count_reg   <= '0;
      wr_prev_reg <= 1'b0;
    end else begin
      control_reg <= control_next;
      chr0_reg    <= chr0_next;
      chr1_reg    <= chr1_next;
      prg_reg     <= prg_next;
      shift_reg   <= shift_next;
      count_reg   <= count_next;
      wr_prev_reg <= cpu_wr;
    end
  end

  // Bank selection, computed at full register width and then wrapped to the fitted bank count.
  logic [3:0]                prg_bank_full;
  logic [4:0]                chr_bank_full;
  logic [PRG_BANKS_LOG2-1:0] prg_bank;
  logic [CHR_BANKS_LOG2-1:0] chr_bank;

  always_comb begin
    prg_bank_full = {3'b000, bus.prg_a_in[14]};
    if (MAPPER == 1) begin
      case (control_reg[3:2])
        2'd2:    prg_bank_full = bus.prg_a_in[14] ? prg_reg[3:0] : 4'd0;
        2'd3:    prg_bank_full = bus.prg_a_in[14] ? 4'hF : prg_reg[3:0];
        default: prg_bank_full = {prg_reg[3:1], bus.prg_a_in[14]};
      endcase
    end
  end

  always_comb begin
    chr_bank_full = {4'b0000, bus.chr_a_in[12]};
    if (MAPPER == 1) begin
      if (control_reg[4]) begin
        chr_bank_full = bus.chr_a_in[12] ? chr1_reg : chr0_reg;
      end else begin
        chr_bank_full = {chr0_reg[4:1], bus.chr_a_in[12]};
      end
    end
  end

  assign prg_bank = prg_bank_full[PRG_BANKS_LOG2-1:0];
  assign chr_bank = chr_bank_full[CHR_BANKS_LOG2-1:0];

  logic ciram_a10;
  always_comb begin
    ciram_a10 = bus.chr_a_in[11];
    if (MAPPER == 1) begin
      case (control_reg[1:0])
        2'd0:    ciram_a10 = 1'b0;
        2'd1:    ciram_a10 = 1'b1;
        2'd2:    ciram_a10 = bus.chr_a_in[10];
        default: ciram_a10 = bus.chr_a_in[11];
      endcase
    end else begin
      ciram_a10 = mirror_cfg_in ? bus.chr_a_in[10] : bus.chr_a_in[11];
    end
  end

  assign bus.ciram_a10_out = ciram_a10;
  assign bus.ciram_nce_out = ~bus.chr_a_in[13];

  // The loader address is widened so the slice stays legal for the largest PRG size.
  logic [17:0] ld_a_ext;
  assign ld_a_ext = {1'b0, bus.ld_a_in};

  logic [PRG_AW-1:0] prg_addr;
  logic              prg_we;
  logic [7:0]        prg_wdata;
  logic [7:0]        prg_mem [PRG_DEPTH];
  logic [7:0]        prg_rdata_reg;
  logic              prg_en_reg;

  always_comb begin
    prg_addr  = {prg_bank, bus.prg_a_in[13:0]};
    prg_we    = (MAPPER == 0) && cpu_wr;
    prg_wdata = bus.prg_d_in;
    if (bus.ld_we_in && !bus.ld_sel_in) begin
      prg_addr  = ld_a_ext[PRG_AW-1:0];
      prg_we    = 1'b1;
      prg_wdata = bus.ld_d_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (prg_we) begin
      prg_mem[prg_addr] <= prg_wdata;
    end
    prg_rdata_reg <= prg_mem[prg_addr];
  end

  logic [CHR_AW-1:0] chr_addr;
  logic              chr_we;
  logic [7:0]        chr_wdata;
  logic [7:0]        chr_mem [CHR_DEPTH];
  logic [7:0]        chr_rdata_reg;
  logic              chr_en_reg;

  always_comb begin
    chr_addr  = {chr_bank, bus.chr_a_in[11:0]};
    chr_we    = (CHR_RAM == 1) && !bus.chr_a_in[13] && !bus.chr_r_nw_in;
    chr_wdata = bus.chr_d_in;
    if (bus.ld_we_in && bus.ld_sel_in) begin
      chr_addr  = ld_a_ext[CHR_AW-1:0];
      chr_we    = 1'b1;
      chr_wdata = bus.ld_d_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (chr_we) begin
      chr_mem[chr_addr] <= chr_wdata;
    end
    chr_rdata_reg <= chr_mem[chr_addr];
  end

  // Enables are kept apart from the RAM read registers so the RAMs carry no reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prg_en_reg <= 1'b0;
      chr_en_reg <= 1'b0;
    end else begin
      prg_en_reg <= ~bus.prg_nce_in;
      chr_en_reg <= ~bus.chr_a_in[13];
    end
  end

  logic [7:0] prg_d_gated;
  logic [7:0] chr_d_gated;
  for (genvar gi = 0; gi < 8; gi++) begin : g_rd_gate
    assign prg_d_gated[gi] = prg_rdata_reg[gi] & prg_en_reg;
    assign chr_d_gated[gi] = chr_rdata_reg[gi] & chr_en_reg;
  end

  assign bus.prg_d_out = prg_d_gated;
  assign bus.chr_d_out = chr_d_gated;

  // prg[4] and the loader bits beyond the RAM size are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{ld_a_ext, prg_reg, prg_bank_full, chr_bank_full,
                         control_reg, chr0_reg, chr1_reg, mirror_cfg_in, bus.chr_d_in};
endmodule
